// File: rtl/sum_pkg.sv
// Shared definitions for the time-multiplexed reduction controller:
// default sizes, FSM state encoding and the index-width helper.
package sum_pkg;

  localparam int LEN_DEFAULT = 32;
  localparam int N_DEFAULT   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to address one of n words (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_seq_ctrl_if.sv
// Vector-in / sum-out handshake bundle for sum_seq_ctrl.
// Optional macro SUM_SEQ_CARRY_CNT_EN adds the carry_cnt signal.
interface sum_seq_ctrl_if
  import sum_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int N   = N_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [N*LEN-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LEN-1:0]   out_data;
  logic             busy;
`ifdef SUM_SEQ_CARRY_CNT_EN
  logic [idx_w(N):0] carry_cnt;
`endif

`ifdef SUM_SEQ_CARRY_CNT_EN
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, carry_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, carry_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif

endinterface

// File: rtl/sum_acc_dp.sv
// Datapath of the reduction controller: captured vector, word mux on the
// running index, and one shared LEN-bit adder feeding the accumulator.
module sum_acc_dp
  import sum_pkg::*;
#(
  parameter  int LEN   = LEN_DEFAULT,
  parameter  int N     = N_DEFAULT,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             add_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [N*LEN-1:0] vec_i,
  output logic [LEN-1:0]   acc_o,
  output logic             carry_o
);

  logic [LEN-1:0] vec_q [N];
  logic [LEN-1:0] word;
  logic [LEN:0]   sum_full;
  logic [LEN-1:0] acc_q;
  logic [LEN-1:0] acc_d;

  // Capture the whole vector on accept; held untouched until the next accept.
  // NOTE: the vector store is pure data qualified by the FSM, so it has no
  // reset; a reset branch would only cost a reset net on every word.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= vec_i[i*LEN +: LEN];
      end
    end
  end

  // Word selected for this cycle's add.
  assign word = vec_q[idx_i];

  // Add with one extra bit; the top bit is the carry-out, the rest wraps.
  assign sum_full = {1'b0, acc_q} + {1'b0, word};
  assign carry_o  = sum_full[LEN];

  // Next accumulator: word 0 straight from the input on accept, else add.
  // NOTE: acc_d is given a default before any branch, so no latch can form.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = vec_i[LEN-1:0];
    end else if (add_en_i) begin
      acc_d = sum_full[LEN-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sum_seq_ctrl.sv
// Time-multiplexed N-word reduction: accepts a vector, sums it with one
// shared adder over N-1 cycles, then presents the result until taken.
// Optional macro SUM_SEQ_CARRY_CNT_EN adds a count of carry-outs per vector.
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int N   = N_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  sum_seq_ctrl_if.slave bus
);

  localparam int               IDX_W    = idx_w(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             accept;
  logic             add_en;
  logic             carry;
  logic [LEN-1:0]   acc;

  assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign add_en = (state_q == ACC);

  sum_acc_dp #(
    .LEN (LEN),
    .N   (N)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .add_en_i (add_en),
    .idx_i    (idx_q),
    .vec_i    (bus.in_data),
    .acc_o    (acc),
    .carry_o  (carry)
  );

  // Control FSM with registered handshake outputs and the word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= ACC;
            idx_q      <= IDX_W'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_q     <= DONE;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = acc;

`ifdef SUM_SEQ_CARRY_CNT_EN
  logic [IDX_W:0] carry_cnt_q;

  // Count adds of the current vector that produced a carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else if (accept) begin
      carry_cnt_q <= '0;
    end else if (add_en) begin
      carry_cnt_q <= carry_cnt_q + (IDX_W + 1)'(carry);
    end
  end

  assign bus.carry_cnt = carry_cnt_q;
`else
  logic carry_unused;
  assign carry_unused = carry;
`endif

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl: table of vectors plus hand-written
// latency, backpressure, busy-input, reset and back-to-back sequences.
// Results are checked by a scoreboard filled at accept time.
module tb_sum_seq_ctrl;
  import sum_pkg::*;

  localparam int LEN    = 32;
  localparam int N      = 8;
  localparam int BUDGET = 200;

  typedef logic [N*LEN-1:0] vec_t;
  typedef struct {
    logic [LEN-1:0] sum;
    int             carry;
  } exp_t;
  typedef struct {
    vec_t           vec;
    logic [LEN-1:0] sum;
    int             carry;
  } vec_rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_seq_ctrl_if #(.LEN(LEN), .N(N)) bus ();

  sum_seq_ctrl #(.LEN(LEN), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   results  = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t fill(input logic [LEN-1:0] w);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*LEN +: LEN] = w;
    return v;
  endfunction

  function automatic vec_t ramp();
    vec_t v;
    for (int i = 0; i < N; i++) v[i*LEN +: LEN] = LEN'(i + 1);
    return v;
  endfunction

  // Reference: sequential wrap-around sum and carry count.
  function automatic exp_t model(input vec_t v);
    exp_t         e;
    logic [LEN:0] s;
    e.sum   = v[LEN-1:0];
    e.carry = 0;
    for (int i = 1; i < N; i++) begin
      s = {1'b0, e.sum} + {1'b0, v[i*LEN +: LEN]};
      if (s[LEN]) e.carry++;
      e.sum = s[LEN-1:0];
    end
    return e;
  endfunction

  // Result monitor: compares each taken result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      results++;
      check("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(e.sum));
`ifdef SUM_SEQ_CARRY_CNT_EN
        check("carry_cnt", 64'(bus.carry_cnt), 64'(e.carry));
`endif
      end
    end
  end

  // Present v (called at a negedge), wait for in_ready, push the expectation
  // and return just after the accept edge with that edge's cycle number.
  task automatic offer(input vec_t v, input exp_t e, input bit keep_valid,
                       output int acc_cyc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_budget", 64'(n < BUDGET), 64'd1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t table_v [7];
    exp_t     e;
    int       t0, t1, tprev, res0;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_signals", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    check("idle_out_data", 64'(bus.out_data), 64'd0);
`ifdef SUM_SEQ_CARRY_CNT_EN
    check("idle_carry_cnt", 64'(bus.carry_cnt), 64'd0);
`endif

    // Basic sum, latency and backpressure.
    e.sum = 32'd36; e.carry = 0;
    offer(ramp(), e, 1'b0, t0);
    for (int k = 0; k < N - 1; k++) begin
      @(negedge clk);
      check("acc_phase", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b001);
    end
    @(negedge clk);
    check("done_valid", 64'(bus.out_valid), 64'd1);
    check("latency", 64'(cyc - t0), 64'(N - 1));
    repeat (5) begin
      @(negedge clk);
      check("hold", 64'({bus.out_valid, bus.in_ready, bus.busy, bus.out_data}),
            {31'd0, 1'b1, 1'b0, 1'b1, 32'd36});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("valid_at_take", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("after_take", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    drain();

    // Table of vectors.
    table_v[0] = '{ramp(), 32'd36, 0};
    table_v[1] = '{fill(32'hFFFF_FFFF), 32'hFFFF_FFF8, 7};
    table_v[2] = '{fill(32'h8000_0000), 32'h0000_0000, 4};
    table_v[3] = '{fill(32'h10), 32'h80, 0};
    table_v[4] = '{fill(32'd100), 32'd800, 0};
    for (int r = 5; r < 7; r++) begin
      for (int i = 0; i < N; i++) table_v[r].vec[i*LEN +: LEN] = $urandom;
      e = model(table_v[r].vec);
      table_v[r].sum   = e.sum;
      table_v[r].carry = e.carry;
    end
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      e.sum = table_v[r].sum; e.carry = table_v[r].carry;
      offer(table_v[r].vec, e, 1'b0, t0);
      drain();
    end

    // Input while busy: second vector must wait for IDLE.
    @(negedge clk);
    e.sum = 32'd36; e.carry = 0;
    offer(ramp(), e, 1'b0, t0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = fill(32'd100);
    check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    e.sum = 32'd800; e.carry = 0;
    offer(fill(32'd100), e, 1'b0, t1);
    check("busy_accept_gap", 64'(t1 - t0), 64'(N + 1));
    drain();

    // Reset in the middle of ACC.
    @(negedge clk);
    e.sum = 32'd36; e.carry = 0;
    offer(ramp(), e, 1'b0, t0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_signals", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e.sum = 32'h80; e.carry = 0;
    offer(fill(32'h10), e, 1'b0, t0);
    drain();

    // Back-to-back with in_valid held high and alternating vectors.
    @(negedge clk);
    res0  = results;
    tprev = 0;
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      if (i % 2 == 0) begin
        v = ramp();
        e.sum = 32'd36;
      end else begin
        v = fill(LEN'(i * 7 + 3));
        e.sum = LEN'(N * (i * 7 + 3));
      end
      e.carry = 0;
      offer(v, e, 1'b1, t0);
      if (i > 0) check("b2b_spacing", 64'(t0 - tprev), 64'(N + 1));
      tprev = t0;
    end
    bus.in_valid = 1'b0;
    drain();
    check("b2b_count", 64'(results - res0), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
